cipher_output_tx: RTL and testbench

CIPHER_OUTPUT_TX -- requirements
Module: cipher_output_tx

---
 rtl/cipher_output_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_cipher_output_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_output_tx.sv
// Cipher text UART transmitter: filters A-Z, buffers them, inserts group spaces and CR LF line breaks.
// Latency: start bit reaches o_tx 2 cycles after an accepted letter when idle; frames run back-to-back.
// Backpressure: none upstream; a letter arriving on a full FIFO without a same-cycle pop is dropped and flagged.
module cipher_output_tx #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH      = 16,
  parameter int GROUP_LEN       = 5,
  parameter int GROUPS_PER_LINE = 6
) (
  input  logic                          i_clock,
  input  logic                          reset,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  input  logic                          i_flush,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_full,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LW = $clog2(GROUP_LEN + 1);
  localparam int GW = $clog2(GROUPS_PER_LINE + 1);
  localparam logic [AW:0] ONE_C  = (AW+1)'(1);
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  SP = 8'h20;
  localparam logic [7:0]  CR = 8'h0D;
  localparam logic [7:0]  LF = 8'h0A;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q;
  logic [CW-1:0]   clk_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      byte_q;
  logic            tx_q, busy_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      sep0_q, sep0_d, sep1_q, sep1_d;
  logic [1:0]      sep_cnt_q, sep_cnt_d;
  logic [LW-1:0]   let_cnt_q, let_cnt_d;
  logic [GW-1:0]   grp_cnt_q, grp_cnt_d;
  logic            flush_pend_q, flush_pend_d;

  logic            is_letter, fifo_empty, sep_empty, full, baud_end, at_slot;
  logic            flush_fire, load_sep, load_fifo, load_any, push, pop;
  logic            let_end, grp_end;
  logic [7:0]      load_byte;

  // A load slot is the idle state or the last cycle of a stop bit, so frames chain with no gap.
  // A flush terminates the line only once the FIFO is drained; it replaces anything queued,
  // which drops a pending group space and never doubles a CR LF already queued at line end.
  assign is_letter  = i_valid && (i_data >= 8'h41) && (i_data <= 8'h5A);
  assign fifo_empty = (count_q == '0);
  assign sep_empty  = (sep_cnt_q == 2'd0);
  assign full       = (count_q == FULL_C);
  assign baud_end   = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign at_slot    = (state_q == IDLE) || ((state_q == STOP) && baud_end);
  assign flush_fire = at_slot && flush_pend_q && fifo_empty && !is_letter;
  assign load_sep   = at_slot && !flush_fire && !sep_empty;
  assign load_fifo  = at_slot && !flush_fire && sep_empty && !fifo_empty;
  assign load_any   = load_sep || load_fifo;
  assign pop        = load_fifo;
  assign push       = is_letter && (!full || pop);
  assign let_end    = (let_cnt_q == LW'(GROUP_LEN - 1));
  assign grp_end    = (grp_cnt_q == GW'(GROUPS_PER_LINE - 1));
  assign load_byte  = load_sep ? sep0_q : mem_q[rd_ptr_q];

  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_full     = full;
  assign o_overflow = ovf_q;
  assign o_count    = count_q;

  // Next state for FIFO bookkeeping, separator queue, grouping counters and flush flag
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ovf_d        = ovf_q | (is_letter & ~push);
    sep0_d       = sep0_q;
    sep1_d       = sep1_q;
    sep_cnt_d    = sep_cnt_q;
    let_cnt_d    = let_cnt_q;
    grp_cnt_d    = grp_cnt_q;
    flush_pend_d = (flush_pend_q & ~flush_fire) | i_flush;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + ONE_C;
    else if (pop && !push) count_d = count_q - ONE_C;
    if (flush_fire) begin
      sep0_d    = CR;
      sep1_d    = LF;
      sep_cnt_d = 2'd2;
      let_cnt_d = '0;
      grp_cnt_d = '0;
    end else if (load_sep) begin
      sep0_d    = sep1_q;
      sep_cnt_d = sep_cnt_q - 2'd1;
    end else if (load_fifo) begin
      if (let_end) begin
        let_cnt_d = '0;
        if (grp_end) begin
          grp_cnt_d = '0;
          sep0_d    = CR;
          sep1_d    = LF;
          sep_cnt_d = 2'd2;
        end else begin
          grp_cnt_d = grp_cnt_q + GW'(1);
          sep0_d    = SP;
          sep_cnt_d = 2'd1;
        end
      end else begin
        let_cnt_d = let_cnt_q + LW'(1);
      end
    end
  end

  // Character storage; contents are don't-care until written, so no reset
  always_ff @(posedge i_clock) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  // Bookkeeping registers
  always_ff @(posedge i_clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      sep0_q       <= 8'h00;
      sep1_q       <= 8'h00;
      sep_cnt_q    <= 2'd0;
      let_cnt_q    <= '0;
      grp_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      sep0_q       <= sep0_d;
      sep1_q       <= sep1_d;
      sep_cnt_q    <= sep_cnt_d;
      let_cnt_q    <= let_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
      flush_pend_q <= flush_pend_d;
      busy_q       <= (state_q != IDLE) || !fifo_empty || !sep_empty;
    end
  end

  // UART framing FSM with registered serial output
  always_ff @(posedge i_clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      byte_q    <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_any) begin
            state_q   <= START;
            clk_cnt_q <= '0;
            byte_q    <= load_byte;
            tx_q      <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            state_q   <= DATA;
            clk_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            tx_q      <= byte_q[0];
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= byte_q[bit_idx_q + 3'd1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            clk_cnt_q <= '0;
            if (load_any) begin
              state_q <= START;
              byte_q  <= load_byte;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cipher_output_tx.sv
// Directed bench for cipher_output_tx with a UART line decoder collecting transmitted bytes.
// Latency: checks start bit timing, bit order, busy drop and reset abort at exact cycles.
// Backpressure: exercises full FIFO, dropped letters, and same-cycle push/pop acceptance.
module tb_cipher_output_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_flush = 1'b0;
  logic       o_tx, o_busy, o_full, o_overflow;
  logic [2:0] o_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q [$];
  logic [7:0] mon_b;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic [2:0] exp_count;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;
  vec_t tbl [10];

  cipher_output_tx #(
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .GROUP_LEN(5), .GROUPS_PER_LINE(2)
  ) dut (
    .i_clock(clk), .reset(rst_n), .i_data(i_data), .i_valid(i_valid), .i_flush(i_flush),
    .o_tx(o_tx), .o_busy(o_busy), .o_full(o_full), .o_overflow(o_overflow), .o_count(o_count)
  );

  always #5 clk = ~clk;

  // Line decoder: samples mid-bit on falling edges, records every byte, checks its stop bit
  always begin
    @(negedge clk);
    if (rst_n && o_tx == 1'b0) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mon_b[i] = o_tx;
      end
      repeat (CPB) @(negedge clk);
      checks++;
      if (o_tx !== 1'b1) begin
        errors++;
        $display("FAIL stop_bit: got %b expected 1 (byte %02h)", o_tx, mon_b);
      end
      rx_q.push_back(mon_b);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rx(input string name, input string exp);
    string a, e;
    bit ok;
    a = "";
    e = "";
    ok = (rx_q.size() == exp.len());
    for (int i = 0; i < rx_q.size(); i++) begin
      a = {a, $sformatf("%02h", rx_q[i])};
      if (ok && rx_q[i] != exp[i]) ok = 1'b0;
    end
    for (int i = 0; i < exp.len(); i++) e = {e, $sformatf("%02h", exp[i])};
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got bytes %s expected %s", name, a, e);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that sampled the inputs
  task automatic drive(input logic [7:0] d, input logic v, input logic f);
    i_data = d;
    i_valid = v;
    i_flush = f;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (3) @(posedge clk);
    #1;
    while (o_busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (o_busy) begin
      errors++;
      $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, o_busy, n);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rx_q.delete();
  endtask

  initial begin
    logic [9:0] frame;

    tbl[0] = '{8'h40, 1'b1, 3'd0, 1'b0, 1'b0};
    tbl[1] = '{8'h42, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[2] = '{8'h5B, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[3] = '{8'h5A, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[4] = '{8'h5A, 1'b1, 3'd2, 1'b0, 1'b0};
    tbl[5] = '{8'h61, 1'b1, 3'd2, 1'b0, 1'b0};
    tbl[6] = '{8'h43, 1'b1, 3'd3, 1'b0, 1'b0};
    tbl[7] = '{8'h44, 1'b1, 3'd4, 1'b1, 1'b0};
    tbl[8] = '{8'h20, 1'b1, 3'd4, 1'b1, 1'b0};
    tbl[9] = '{8'h45, 1'b1, 3'd4, 1'b1, 1'b1};

    // Reset state while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", o_tx, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_full", o_full, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_count", o_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single 'Q' frame: exact waveform and busy drop
    frame = {1'b1, 8'h51, 1'b0};
    drive(8'h51, 1'b1, 1'b0);
    chk("q_pre_start_tx", o_tx, 1);
    for (int c = 0; c < 10 * CPB; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("q_tx_c%0d", c), o_tx, frame[c / CPB]);
      chk($sformatf("q_busy_c%0d", c), o_busy, 1);
    end
    @(posedge clk);
    #1;
    chk("q_after_stop_tx", o_tx, 1);
    chk("q_after_stop_busy", o_busy, 1);
    @(posedge clk);
    #1;
    chk("q_busy_drop", o_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check_rx("q_rx", "Q");

    // Grouping and line break across eleven paced letters
    do_reset();
    begin
      string s;
      s = "ABCDEFGHIJK";
      for (int i = 0; i < s.len(); i++) begin
        drive(s[i], 1'b1, 1'b0);
        repeat (44) @(posedge clk);
        #1;
      end
    end
    wait_idle("group");
    check_rx("group_rx", "ABCDE FGHIJ\015\012K");
    chk("group_ovf", o_overflow, 0);

    // Letter filter, occupancy, full and overflow from a vector table during one frame
    do_reset();
    drive(8'h41, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      i_data = tbl[i].data;
      i_valid = tbl[i].valid;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_count", i), o_count, tbl[i].exp_count);
      chk($sformatf("tbl%0d_full", i), o_full, tbl[i].exp_full);
      chk($sformatf("tbl%0d_ovf", i), o_overflow, tbl[i].exp_ovf);
    end
    i_valid = 1'b0;
    wait_idle("tbl");
    check_rx("tbl_rx", "ABZCD ");
    chk("tbl_ovf_sticky", o_overflow, 1);

    // Six consecutive letters: one popped, four fill, sixth dropped
    do_reset();
    drive(8'h41, 1'b1, 1'b0);
    drive(8'h42, 1'b1, 1'b0);
    drive(8'h43, 1'b1, 1'b0);
    drive(8'h44, 1'b1, 1'b0);
    drive(8'h45, 1'b1, 1'b0);
    chk("six_full", o_full, 1);
    chk("six_count", o_count, 4);
    chk("six_ovf_before", o_overflow, 0);
    drive(8'h46, 1'b1, 1'b0);
    chk("six_ovf", o_overflow, 1);
    chk("six_count_after", o_count, 4);
    wait_idle("six");
    check_rx("six_rx", "ABCDE ");
    chk("six_ovf_sticky", o_overflow, 1);

    // Flush after two letters, then letter plus discarded non-letters
    do_reset();
    drive(8'h41, 1'b1, 1'b0);
    drive(8'h42, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b1);
    wait_idle("flush1");
    drive(8'h43, 1'b1, 1'b0);
    chk("flush_c_count", o_count, 1);
    drive(8'h20, 1'b1, 1'b0);
    chk("flush_sp_count", o_count, 0);
    drive(8'h31, 1'b1, 1'b0);
    chk("flush_31_count", o_count, 0);
    wait_idle("flush2");
    check_rx("flush_rx", "AB\015\012C");
    chk("flush_ovf", o_overflow, 0);

    // Letter plus flush on a full FIFO exactly in the pop cycle at a stop-bit end
    do_reset();
    drive(8'h41, 1'b1, 1'b0);
    drive(8'h42, 1'b1, 1'b0);
    drive(8'h43, 1'b1, 1'b0);
    drive(8'h44, 1'b1, 1'b0);
    drive(8'h45, 1'b1, 1'b0);
    repeat (36) @(posedge clk);
    #1;
    chk("same_pre_full", o_full, 1);
    chk("same_pre_count", o_count, 4);
    drive(8'h46, 1'b1, 1'b1);
    chk("same_count", o_count, 4);
    chk("same_ovf", o_overflow, 0);
    wait_idle("same");
    check_rx("same_rx", "ABCDE F\015\012");
    chk("same_ovf_end", o_overflow, 0);

    // Reset during data bit 3 of 'Z', then a push on the first edge after release
    do_reset();
    drive(8'h5A, 1'b1, 1'b0);
    repeat (18) @(posedge clk);
    #1;
    chk("abort_busy_before", o_busy, 1);
    chk("abort_bit3", o_tx, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", o_tx, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_count", o_count, 0);
    chk("abort_full", o_full, 0);
    chk("abort_ovf", o_overflow, 0);
    repeat (30) @(negedge clk);
    rx_q.delete();
    i_data = 8'h4B;
    i_valid = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    chk("post_rst_count", o_count, 1);
    wait_idle("post_rst");
    check_rx("post_rst_rx", "K");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
